btn_toggle_cond: RTL and testbench

//   Conditions a raw push-button into a clean single-cycle T pulse per press.

---
 rtl/btn_toggle_cond.sv | 145 ++++++++++++++
 tb/tb_btn_toggle_cond.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_toggle_cond.sv
// btn_toggle_cond: raw push-button conditioner producing a one-cycle T pulse per press.
// Path: BtnIn -> 2-flop synchroniser -> debounce FSM -> registered T / Stable.
// Optional auto-repeat while held: define BTN_AUTOREPEAT_EN (default build has it disabled).
module btn_toggle_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic BtnIn,
  output logic T,
  output logic Stable
);

  // One counter width serves every count so the debounce and repeat counters share a size.
  localparam int unsigned MaxDr    = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                                       : REPEAT_DELAY;
  localparam int unsigned MaxCount = (MaxDr > REPEAT_PERIOD) ? MaxDr : REPEAT_PERIOD;
  localparam int unsigned CntW     = $clog2(MaxCount) + 1;

  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWaitHi,
    StHeld,
    StWaitLo
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            s1_q;
  logic            s2_q;
  logic            t_q;
  logic            stable_q;

`ifdef BTN_AUTOREPEAT_EN
  // Repeat pulses land REPEAT_DELAY-1 edges after entering HELD, then every REPEAT_PERIOD
  // edges. REPEAT_DELAY must be at least 2 for the first repeat to be reachable.
  localparam logic [CntW-1:0] RepFirst  = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RepPeriod = CntW'(REPEAT_PERIOD);

  logic [CntW-1:0] rep_cnt_q;
  logic            rep_phase_q;
  logic [CntW-1:0] rep_next;
  logic [CntW-1:0] rep_target;

  // Next repeat count and the count that fires the next repeat pulse.
  always_comb begin
    rep_next   = rep_cnt_q + 1'b1;
    rep_target = rep_phase_q ? RepPeriod : RepFirst;
  end
`endif

  // Two-flop synchroniser; the FSM only ever looks at s2_q.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= BtnIn;
      s2_q <= s1_q;
    end
  end

  // Debounce FSM with registered T pulse and debounced level.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      t_q         <= 1'b0;
      stable_q    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
`endif
    end else begin
      // T is a single-cycle pulse unless a branch below re-asserts it.
      t_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s2_q) begin
            state_q <= StWaitHi;
            cnt_q   <= '0;
          end
        end
        StWaitHi: begin
          if (!s2_q) begin
            state_q <= StIdle;
          end else if (cnt_q == DebLast) begin
            state_q  <= StHeld;
            t_q      <= 1'b1;
            stable_q <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHeld: begin
          if (!s2_q) begin
            // Repeat counter is left untouched so a release glitch only pauses it.
            state_q <= StWaitLo;
            cnt_q   <= '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (rep_next == rep_target) begin
            t_q         <= 1'b1;
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b1;
          end else begin
            rep_cnt_q <= rep_next;
          end
`endif
        end
        StWaitLo: begin
          if (s2_q) begin
            state_q <= StHeld;
          end else if (cnt_q == DebLast) begin
            state_q  <= StIdle;
            stable_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end
      endcase
    end
  end

  assign T      = t_q;
  assign Stable = stable_q;

endmodule

// File: tb/tb_btn_toggle_cond.sv
// tb_btn_toggle_cond: scoreboard bench for btn_toggle_cond with DEBOUNCE_CYCLES=4.
// Stimulus pushes the edge index of every expected T pulse; a monitor pops on each pulse.
module tb_btn_toggle_cond;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  logic Clk   = 1'b0;
  logic Rst   = 1'b1;
  logic BtnIn = 1'b0;
  logic T;
  logic Stable;
  logic tff_q;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  btn_toggle_cond #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .BtnIn (BtnIn),
    .T     (T),
    .Stable(Stable)
  );

  always #10 Clk = ~Clk;

  // Edge index: value seen at a negedge is the number of rising edges so far.
  always @(posedge Clk) cyc <= cyc + 1;

  // Downstream toggle flip-flop driven by T.
  always @(posedge Clk or posedge Rst) begin
    if (Rst) tff_q <= 1'b0;
    else if (T) tff_q <= ~tff_q;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_negs(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Expected auto-repeat pulses: HELD entry edge h, last HELD edge still seeing the press.
  task automatic push_repeats(input int h, input int last);
    for (int e = h + 9; e <= last; e += 5) begin
      if (AutoRep) exp_q.push_back(e);
    end
  endtask

  task automatic drive_check(input logic lvl, input int n, input int exp_stable,
                             input string name);
    BtnIn = lvl;
    repeat (n) begin
      @(negedge Clk);
      check(name, int'(Stable), exp_stable);
    end
  endtask

  // Monitor: every T pulse must match the oldest pending expectation.
  always @(negedge Clk) begin
    int e;
    if (!Rst && T) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL t_pulse: unexpected pulse after edge %0d, none expected", cyc);
      end else begin
        e = exp_q.pop_front();
        check("t_pulse_edge", cyc, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // Reset state.
    wait_negs(2);
    check("reset_t", int'(T), 0);
    check("reset_stable", int'(Stable), 0);
    Rst = 1'b0;
    wait_negs(3);

    // 1: clean press, T after edge c+7, release back to IDLE 7 edges after first 0 sample.
    c = cyc;
    BtnIn = 1'b1;
    exp_q.push_back(c + 7);
    push_repeats(c + 7, c + 22);
    wait_negs(6);
    check("t1_stable_before", int'(Stable), 0);
    wait_negs(1);
    check("t1_stable_held", int'(Stable), 1);
    wait_negs(13);
    BtnIn = 1'b0;
    wait_negs(6);
    check("t1_stable_release_pre", int'(Stable), 1);
    wait_negs(1);
    check("t1_stable_release", int'(Stable), 0);
    wait_negs(4);

    // 2: bounce never reaches the terminal count.
    drive_check(1'b1, 3, 0, "t2_bounce_hi1");
    drive_check(1'b0, 2, 0, "t2_bounce_lo");
    drive_check(1'b1, 3, 0, "t2_bounce_hi2");
    drive_check(1'b0, 8, 0, "t2_bounce_tail");

    // 3: release glitch keeps Stable high and makes no new T.
    c = cyc;
    BtnIn = 1'b1;
    exp_q.push_back(c + 7);
    wait_negs(7);
    check("t3_stable_held", int'(Stable), 1);
    wait_negs(1);
    BtnIn = 1'b0;
    wait_negs(2);
    BtnIn = 1'b1;
    wait_negs(1);
    check("t3_stable_glitch_a", int'(Stable), 1);
    wait_negs(1);
    check("t3_stable_glitch_b", int'(Stable), 1);
    BtnIn = 1'b0;
    wait_negs(6);
    check("t3_stable_release_pre", int'(Stable), 1);
    wait_negs(1);
    check("t3_stable_release", int'(Stable), 0);
    wait_negs(4);

    // 4: reset during WAIT_HI with button held, then reset during HELD.
    c = cyc;
    BtnIn = 1'b1;
    wait_negs(5);
    Rst = 1'b1;
    #1;
    check("t4_rst_t", int'(T), 0);
    check("t4_rst_stable", int'(Stable), 0);
    wait_negs(2);
    Rst = 1'b0;
    c = cyc;
    exp_q.push_back(c + 7);
    wait_negs(6);
    check("t4_stable_before", int'(Stable), 0);
    wait_negs(1);
    check("t4_stable_held", int'(Stable), 1);
    wait_negs(1);
    Rst = 1'b1;
    #1;
    check("t4_rst_held_stable", int'(Stable), 0);
    check("t4_rst_held_t", int'(T), 0);
    check("t4_tff_reset", int'(tff_q), 0);
    BtnIn = 1'b0;
    wait_negs(2);
    Rst = 1'b0;
    wait_negs(3);

    // 5: three presses toggle the downstream flip-flop 1, 0, 1.
    for (int i = 0; i < 3; i++) begin
      c = cyc;
      BtnIn = 1'b1;
      exp_q.push_back(c + 7);
      wait_negs(8);
      check("t5_tff_q", int'(tff_q), (i % 2 == 0) ? 1 : 0);
      BtnIn = 1'b0;
      wait_negs(10);
    end

    // 6: long hold; auto-repeat pulses only when the feature is built in.
    c = cyc;
    BtnIn = 1'b1;
    exp_q.push_back(c + 7);
    push_repeats(c + 7, c + 37);
    wait_negs(35);
    check("t6_stable_long_hold", int'(Stable), 1);
    BtnIn = 1'b0;
    wait_negs(12);
    check("t6_stable_after", int'(Stable), 0);

    wait_negs(5);
    check("pending_pulses", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
